// File: rtl/fact_cu.sv
// Factorial control unit.
// Sequences the factorial datapath (counter + product register) from its two
// comparator flags, exposes a go/busy/done/err handshake to the register
// side, and measures how many cycles the last operation took.
//
// Datapath controls:
//   load_cnt : counter <= n
//   en       : counter <= counter - 1
//   sel_1    : product source, 0 = constant 1, 1 = product * counter
//   load_reg : product register write enable
//   sel_2    : result output enable (nf valid)
//
// Operation for a start with n <= 12:
//   start cycle : counter <= n, product <= 1
//   CHECK       : counter > 1 ? MULT : DONE
//   MULT        : product <= product * counter, counter--, back to CHECK
// An n of 0 or 1 leaves CHECK straight for DONE with product 1.
// A start with n > 12 goes directly to ERR and nothing is multiplied.

module fact_cu #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active low
  input  logic             go,
  input  logic             gt_in,
  input  logic             gt_fact,
  output logic             load_cnt,
  output logic             en,
  output logic             sel_1,
  output logic             load_reg,
  output logic             sel_2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CYC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);

  state_t state;
  state_t next_state;
  logic   go_q;
  logic   start;
  logic   count_en;

  // A start is a rising edge of go. go_q resets to 1 so that a go level
  // already high when reset is released is not mistaken for a request.
  assign start = go & ~go_q;

  // State register and go edge detector.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      go_q  <= 1'b1;
    end else begin
      state <= next_state;
      go_q  <= go;
    end
  end

  // Next-state decode plus Moore outputs and the Mealy start actions.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    load_cnt   = 1'b0;
    en         = 1'b0;
    sel_1      = 1'b0;
    load_reg   = 1'b0;
    sel_2      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          load_cnt   = 1'b1;
          load_reg   = 1'b1;
          next_state = gt_in ? ERR : CHECK;
        end
      end

      CHECK: begin
        busy       = 1'b1;
        next_state = gt_fact ? MULT : DONE;
      end

      MULT: begin
        busy       = 1'b1;
        sel_1      = 1'b1;
        load_reg   = 1'b1;
        en         = 1'b1;
        next_state = CHECK;
      end

      DONE: begin
        // done and sel_2 are Moore outputs: they drop in the state that
        // follows a restart, even though the start actions fire here.
        done  = 1'b1;
        sel_2 = 1'b1;
        if (start) begin
          load_cnt   = 1'b1;
          load_reg   = 1'b1;
          next_state = gt_in ? ERR : CHECK;
        end
      end

      ERR: begin
        err = 1'b1;
        if (start) begin
          load_cnt   = 1'b1;
          load_reg   = 1'b1;
          next_state = gt_in ? ERR : CHECK;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The counter advances while the operation is in flight: on edges heading
  // into CHECK/MULT and on the edge leaving CHECK (which may be into DONE).
  assign count_en = (next_state == CHECK) || (next_state == MULT) ||
                    (state == CHECK);

  // Busy-cycle counter. A start clears it and counts its own edge as the
  // first cycle, so DONE entry reads 2*max(n,1) and ERR entry reads 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles <= '0;
    end else if (start && (state == IDLE || state == DONE || state == ERR)) begin
      cycles <= CYC_ONE;
    end else if (count_en && cycles != CYC_MAX) begin
      cycles <= cycles + CYC_ONE;
    end
  end

endmodule

// File: tb/tb_fact_cu.sv
// Self-checking bench for fact_cu. A small behavioural model of the factorial
// datapath is driven by the DUT's control outputs and feeds back the gt_in and
// gt_fact flags, so the product nf can be checked against hand-computed values.

module tb_fact_cu;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             go;
  logic             gt_in;
  logic             gt_fact;
  logic             load_cnt;
  logic             en;
  logic             sel_1;
  logic             load_reg;
  logic             sel_2;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] cycles;

  fact_cu #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .gt_in    (gt_in),
    .gt_fact  (gt_fact),
    .load_cnt (load_cnt),
    .en       (en),
    .sel_1    (sel_1),
    .load_reg (load_reg),
    .sel_2    (sel_2),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cycles   (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: down-counter and product register, not reset.
  int unsigned   n_in;
  int unsigned   cnt;
  logic [31:0]   prod;
  logic [31:0]   nf;

  assign gt_in   = (n_in > 12);
  assign gt_fact = (cnt > 1);
  assign nf      = sel_2 ? prod : 32'd0;

  always @(posedge clk) begin
    if (load_cnt)      cnt <= n_in;
    else if (en)       cnt <= cnt - 1;
    if (load_reg)      prod <= sel_1 ? prod * cnt : 32'd1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int unsigned n;
    logic [31:0] nf;
    int          cyc;
    int          mults;
    logic        is_err;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  // One operation: raise go with n, check the start-cycle actions, wait
  // (bounded) for DONE/ERR while counting MULT pulses, then check results.
  // go toggles for the first tog_cycles busy cycles, then stays low.
  task automatic run_op(input string tag, input int unsigned n, input logic [31:0] exp_nf,
                        input int exp_cyc, input int exp_mults, input logic exp_err,
                        input int exp_lat, input int tog_cycles);
    int   lat;
    int   mults;
    logic fin;
    logic both;
    @(posedge clk); #1;
    n_in = n;
    go   = 1'b1;
    @(negedge clk);
    check({tag, " start ctl"}, 32'({load_cnt, load_reg, sel_1, en}), 32'b1100);
    lat   = 0;
    mults = 0;
    fin   = 1'b0;
    both  = 1'b0;
    while (!fin && lat < 60) begin
      @(posedge clk); #1;
      if (lat < tog_cycles) go = ~go;
      else                  go = 1'b0;
      @(negedge clk);
      lat++;
      if (en) mults++;
      if (done && err) both = 1'b1;
      if (done || err) fin = 1'b1;
    end
    check({tag, " finished"}, 32'(fin), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " done"}, 32'(done), 32'(!exp_err));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " sel_2"}, 32'(sel_2), 32'(!exp_err));
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " nf"}, nf, exp_nf);
    check({tag, " cycles"}, 32'(cycles), 32'(exp_cyc));
    check({tag, " mult pulses"}, 32'(mults), 32'(exp_mults));
    check({tag, " done&err"}, 32'(both), 32'd0);
    // Result must hold with no new start.
    repeat (3) @(negedge clk);
    check({tag, " hold"}, 32'({done, err, sel_2, busy, load_cnt}),
          exp_err ? 32'b01000 : 32'b10100);
    check({tag, " hold cycles"}, 32'(cycles), 32'(exp_cyc));
  endtask

  initial begin
    vecs[0] = '{n: 5,  nf: 32'd120, cyc: 10, mults: 4, is_err: 1'b0, lat: 10};
    vecs[1] = '{n: 0,  nf: 32'd1,   cyc: 2,  mults: 0, is_err: 1'b0, lat: 2};
    vecs[2] = '{n: 1,  nf: 32'd1,   cyc: 2,  mults: 0, is_err: 1'b0, lat: 2};
    vecs[3] = '{n: 13, nf: 32'd0,   cyc: 1,  mults: 0, is_err: 1'b1, lat: 1};
    vecs[4] = '{n: 3,  nf: 32'd6,   cyc: 6,  mults: 2, is_err: 1'b0, lat: 6};

    // Reset with go held high; releasing reset must not count as a start.
    rst  = 1'b0;
    go   = 1'b1;
    n_in = 5;
    repeat (2) @(negedge clk);
    check("in reset outputs", 32'({load_cnt, en, sel_1, load_reg, sel_2, busy, done, err}), 32'd0);
    check("in reset cycles", 32'(cycles), 32'd0);
    #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("go held: busy", 32'(busy), 32'd0);
      check("go held: load_cnt", 32'(load_cnt), 32'd0);
      check("go held: done/err", 32'({done, err}), 32'd0);
    end
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_op($sformatf("n=%0d", vecs[v].n), vecs[v].n, vecs[v].nf, vecs[v].cyc,
             vecs[v].mults, vecs[v].is_err, vecs[v].lat, 0);
    end

    // n=12 with go toggling during the multiply loop: toggles ignored.
    run_op("n=12 toggles", 12, 32'd479001600, 24, 11, 1'b0, 24, 10);

    // Reset during the third MULT of an n=7 run.
    begin
      int   mults;
      int   guard;
      @(posedge clk); #1;
      n_in = 7;
      go   = 1'b1;
      @(posedge clk); #1 go = 1'b0;
      mults = 0;
      guard = 0;
      @(negedge clk);
      while (mults < 3 && guard < 40) begin
        if (en) mults++;
        if (mults < 3) begin
          @(negedge clk);
          guard++;
        end
      end
      check("n=7 reached 3rd MULT", 32'(mults), 32'd3);
      check("n=7 in MULT", 32'({busy, en, sel_1, load_reg}), 32'b1111);
      #1 rst = 1'b0;
      #1;
      check("mid reset outputs", 32'({load_cnt, en, sel_1, load_reg, sel_2, busy, done, err}), 32'd0);
      check("mid reset cycles", 32'(cycles), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("after reset idle", 32'({busy, done, err, load_cnt}), 32'd0);
    end

    run_op("n=4 after reset", 4, 32'd24, 8, 3, 1'b0, 8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
